// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_AW    = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps,
// so the most recently granted requester has the lowest priority.
module rr_arbiter
#(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
)
(
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            found
);
    import regfile_pkg::*;

    int cand;

    // Walk requesters in rotated order and grant the first one that is valid.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regfile write port between NREQ writeback sources with
// round-robin arbitration, registers the winning write, and keeps a busy
// scoreboard of destination registers that still have a write outstanding.
// Optional macro RF_BYPASS_EN adds two forwarding read ports that observe the
// registered write in the same cycle the regfile commits it.
//
// Handshake: a source raises req_valid[i] and holds valid/addr/data stable
// until it sees req_ready[i]; the transfer happens on the clock edge where
// both are high. req_ready is one-hot (or zero) and never depends on
// anything but req_valid, the round-robin pointer and rst.
module regfile_wb_arbiter
#(
    parameter int NREQ      = 3,
    parameter int WORD_SIZE = regfile_pkg::WORD_SIZE,
    parameter int REG_AW    = regfile_pkg::REG_AW
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*REG_AW-1:0]      req_addr,
    input  logic [NREQ*WORD_SIZE-1:0]   req_data,
    input  logic                        issue_valid,
    input  logic [REG_AW-1:0]           issue_rd,
    output logic [regfile_pkg::NUM_REGS-1:0] busy,
    output logic                        rf_wr,
    output logic [REG_AW-1:0]           rf_addr3,
    output logic [WORD_SIZE-1:0]        rf_data3
`ifdef RF_BYPASS_EN
    ,
    input  logic [REG_AW-1:0]           rd_addr1,
    input  logic [REG_AW-1:0]           rd_addr2,
    output logic                        fwd1_hit,
    output logic                        fwd2_hit,
    output logic [WORD_SIZE-1:0]        fwd1_data,
    output logic [WORD_SIZE-1:0]        fwd2_data
`endif
);
    import regfile_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]       ptr;
    logic [PW-1:0]       grant_idx;
    logic [NREQ-1:0]     grant;
    logic                grant_found;
    logic                accept;
    logic [REG_AW-1:0]   sel_addr;
    logic [WORD_SIZE-1:0] sel_data;
    logic [NUM_REGS-1:0] busy_next;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_found)
    );

    // No grants while in reset, so nothing can be lost on a reset edge.
    assign req_ready = rst ? '0 : grant;
    assign accept    = grant_found & ~rst;
    assign sel_addr  = req_addr[grant_idx*REG_AW +: REG_AW];
    assign sel_data  = req_data[grant_idx*WORD_SIZE +: WORD_SIZE];

    // Output register and round-robin pointer; x0 writes are consumed but never reach the regfile.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr    <= 1'b0;
            rf_addr3 <= '0;
            rf_data3 <= '0;
            ptr      <= PW'(NREQ - 1);
        end else begin
            rf_wr <= accept && (sel_addr != '0);
            if (accept) begin
                ptr <= grant_idx;
                if (sel_addr != '0) begin
                    rf_addr3 <= sel_addr;
                    rf_data3 <= sel_data;
                end
            end
        end
    end

    // Scoreboard update: the commit clears first, then a new issue sets, so a same-register issue wins.
    always_comb begin
        busy_next = busy;
        if (rf_wr) begin
            busy_next[rf_addr3] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

`ifdef RF_BYPASS_EN
    assign fwd1_hit  = rf_wr && (rf_addr3 == rd_addr1) && (rd_addr1 != '0);
    assign fwd2_hit  = rf_wr && (rf_addr3 == rd_addr2) && (rd_addr2 != '0);
    assign fwd1_data = rf_data3;
    assign fwd2_data = rf_data3;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (NREQ=3). A table of per-cycle
// vectors covers the arbitration, scoreboard and x0 behaviour; reset and the
// reset-after-accept case are written out by hand.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        iv;
        logic [4:0]  ird;
        logic [2:0]  exp_ready;
        logic        exp_wr;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   req_valid = '0;
    logic [2:0]   req_ready;
    logic [14:0]  req_addr = '0;
    logic [95:0]  req_data = '0;
    logic         issue_valid = 1'b0;
    logic [4:0]   issue_rd = '0;
    logic [31:0]  busy;
    logic         rf_wr;
    logic [4:0]   rf_addr3;
    logic [31:0]  rf_data3;
`ifdef RF_BYPASS_EN
    logic [4:0]   rd_addr1 = '0;
    logic [4:0]   rd_addr2 = '0;
    logic         fwd1_hit, fwd2_hit;
    logic [31:0]  fwd1_data, fwd2_data;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    regfile_wb_arbiter #(.NREQ(3), .WORD_SIZE(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .rf_wr       (rf_wr),
        .rf_addr3    (rf_addr3),
        .rf_data3    (rf_data3)
`ifdef RF_BYPASS_EN
        ,
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .fwd1_hit    (fwd1_hit),
        .fwd2_hit    (fwd2_hit),
        .fwd1_data   (fwd1_data),
        .fwd2_data   (fwd2_data)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] valid, input logic [4:0] a0, a1, a2,
                                input logic [31:0] d0, d1, d2, input logic iv,
                                input logic [4:0] ird, input logic [2:0] er, input logic ew,
                                input logic [4:0] ea, input logic [31:0] ed, input logic [31:0] eb);
        vec_t v;
        v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.iv = iv; v.ird = ird;
        v.exp_ready = er; v.exp_wr = ew; v.exp_addr = ea; v.exp_data = ed; v.exp_busy = eb;
        return v;
    endfunction

    // All three sources valid with addresses 1/2/3 and data 0x11/0x22/0x33.
    function automatic vec_t all3(input logic [2:0] er, input logic [4:0] ea,
                                  input logic [31:0] ed, input logic [31:0] eb);
        return mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, er, 1'b1, ea, ed, eb);
    endfunction

    function automatic vec_t idle(input logic iv, input logic [4:0] ird, input logic [31:0] eb);
        return mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, iv, ird, 3'b000, 1'b0, 5'd0, 32'h0, eb);
    endfunction

    task automatic drive(input vec_t v);
        req_valid   = v.valid;
        req_addr    = {v.a2, v.a1, v.a0};
        req_data    = {v.d2, v.d1, v.d0};
        issue_valid = v.iv;
        issue_rd    = v.ird;
    endtask

    initial begin
        vec_t v;

        // Test 2: single request from source 0 (pointer starts at 2 -> source 0 first)
        vecs.push_back(mk(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd0,
                          3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0));
        vecs.push_back(idle(1'b0, 5'd0, 32'h0));
        // Test 3: all valid, pointer now 0 -> grants 1,2,0,1 back to back
        vecs.push_back(all3(3'b010, 5'd2, 32'h22, 32'h0));
        vecs.push_back(all3(3'b100, 5'd3, 32'h33, 32'h0));
        vecs.push_back(all3(3'b001, 5'd1, 32'h11, 32'h0));
        vecs.push_back(all3(3'b010, 5'd2, 32'h22, 32'h0));
        // Test 4: issue rd=7, write it back via source 1, busy clears on the commit edge
        vecs.push_back(idle(1'b1, 5'd7, 32'h80));
        vecs.push_back(mk(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h77, 32'h0, 1'b0, 5'd0,
                          3'b010, 1'b1, 5'd7, 32'h77, 32'h80));
        vecs.push_back(idle(1'b0, 5'd0, 32'h0));
        // Re-issue on the same edge as the commit keeps the bit set
        vecs.push_back(idle(1'b1, 5'd7, 32'h80));
        vecs.push_back(mk(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h78, 32'h0, 1'b0, 5'd0,
                          3'b010, 1'b1, 5'd7, 32'h78, 32'h80));
        vecs.push_back(idle(1'b1, 5'd7, 32'h80));
        // Issue to x0 never marks anything busy
        vecs.push_back(idle(1'b1, 5'd0, 32'h80));
        // Test 5: x0 writeback from source 2 is accepted but not written
        vecs.push_back(mk(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1234, 1'b0, 5'd0,
                          3'b100, 1'b0, 5'd0, 32'h0, 32'h80));
        // Pointer moved to 2, so source 0 wins next
        vecs.push_back(all3(3'b001, 5'd1, 32'h11, 32'h80));
        vecs.push_back(idle(1'b0, 5'd0, 32'h80));

        // Test 1: reset for two cycles, then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr", {31'd0, rf_wr}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_addr", {27'd0, rf_addr3}, 32'd0);
        chk("rst_data", rf_data3, 32'd0);
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d_wr", i), {31'd0, rf_wr}, 32'd0);
            chk($sformatf("idle%0d_busy", i), busy, 32'd0);
            chk($sformatf("idle%0d_ready", i), {29'd0, req_ready}, 32'd0);
        end

        // Table: drive, check grant, clock, check registered outputs
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            #1;
            chk($sformatf("v%0d_ready", i), {29'd0, req_ready}, {29'd0, v.exp_ready});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr", i), {31'd0, rf_wr}, {31'd0, v.exp_wr});
            if (v.exp_wr) begin
                chk($sformatf("v%0d_addr", i), {27'd0, rf_addr3}, {27'd0, v.exp_addr});
                chk($sformatf("v%0d_data", i), rf_data3, v.exp_data);
            end
            chk($sformatf("v%0d_busy", i), busy, v.exp_busy);
        end

        // Test 6: accept source 0 writing r9 (also issued), then reset the next cycle
        drive(mk(3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b1, 5'd9,
                 3'b001, 1'b1, 5'd9, 32'h99, 32'h280));
        #1;
        chk("t6_ready", {29'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("t6_wr", {31'd0, rf_wr}, 32'd1);
        chk("t6_addr", {27'd0, rf_addr3}, 32'd9);
        chk("t6_data", rf_data3, 32'h99);
        chk("t6_busy", busy, 32'h280);
`ifdef RF_BYPASS_EN
        rd_addr1 = 5'd9;
        rd_addr2 = 5'd0;
        #1;
        chk("t6_fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
        chk("t6_fwd1_data", fwd1_data, 32'h99);
        chk("t6_fwd2_hit", {31'd0, fwd2_hit}, 32'd0);
`endif
        issue_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_ready_in_rst", {29'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("t6_rst_wr", {31'd0, rf_wr}, 32'd0);
        chk("t6_rst_busy", busy, 32'd0);
`ifdef RF_BYPASS_EN
        chk("t6_rst_fwd1", {31'd0, fwd1_hit}, 32'd0);
`endif
        rst = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("t6_after_wr", {31'd0, rf_wr}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
